// File: rtl/rob_wb_arbiter_pkg.sv
// Shared out-of-order core definitions: ROB tag/data widths, FU count and the
// writeback bundle exchanged between functional units and the ROB.
package rob_wb_arbiter_pkg;

  localparam int WB_TAG_W  = 5;   // 32-entry ROB index
  localparam int WB_DATA_W = 32;
  localparam int NUM_FU    = 4;

  typedef struct packed {
    logic [WB_TAG_W-1:0]  tag;
    logic [WB_DATA_W-1:0] data;
  } wb_t;

endpackage

// File: rtl/rob_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first set request at or after
// ptr (wrapping). Reused by the issue-select logic.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            grant_valid,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    grant_valid = 1'b0;
    grant       = '0;
    grant_id    = '0;
    idx         = 0;
    // Scan from the farthest offset down so the nearest request to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant       = '0;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Round-robin arbiter sharing the ROB's single result-write port among the
// functional units, with one registered output stage, stall hold and flush.
module rob_wb_arbiter
  import rob_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_FU,
  parameter int TAG_W   = WB_TAG_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rob_stall,
  input  logic                      flush,
  output logic                      rob_write,
  output logic [TAG_W-1:0]          rob_idx,
  output logic [DATA_W-1:0]         rob_value,
  output logic [ID_W-1:0]           last_grant
);

  logic [ID_W-1:0]    rr_ptr;
  logic               stage_free;
  logic               arb_en;
  logic [NUM_REQ-1:0] pick_req;
  logic               grant_valid;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    next_ptr;

  // A pending write only blocks the stage while the ROB is stalling it.
  assign stage_free = !rob_write || !rob_stall;
  assign arb_en     = stage_free && !flush && !rst;
  assign pick_req   = req_valid & {NUM_REQ{arb_en}};
  assign req_ready  = grant;
  assign next_ptr   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req         (pick_req),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant       (grant),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rob_write  <= 1'b0;
      rob_idx    <= '0;
      rob_value  <= '0;
      last_grant <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      // Squash any pending (possibly stalled) write; index/value are don't-care.
      rob_write <= 1'b0;
      rr_ptr    <= '0;
    end else if (stage_free) begin
      if (grant_valid) begin
        rob_write  <= 1'b1;
        rob_idx    <= req_tag[grant_id*TAG_W +: TAG_W];
        rob_value  <= req_data[grant_id*DATA_W +: DATA_W];
        last_grant <= grant_id;
        rr_ptr     <= next_ptr;
      end else begin
        rob_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter with a per-cycle reference model and
// hand-computed literal checks for each scenario.
module tb_rob_wb_arbiter;
  import rob_wb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rob_stall;
  logic            flush;
  logic            rob_write;
  logic [TW-1:0]   rob_idx;
  logic [DW-1:0]   rob_value;
  logic [IW-1:0]   last_grant;

  wb_t fu [N];

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  rob_wb_arbiter #(
    .NUM_REQ (N),
    .TAG_W   (TW),
    .DATA_W  (DW),
    .ID_W    (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_tag    (req_tag),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rob_stall  (rob_stall),
    .flush      (flush),
    .rob_write  (rob_write),
    .rob_idx    (rob_idx),
    .rob_value  (rob_value),
    .last_grant (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_tag  = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = fu[i].tag;
      req_data[i*DW +: DW] = fu[i].data;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pending ROB write and the next requester in line.
  logic          m_write = 1'b0;
  logic [TW-1:0] m_idx   = '0;
  logic [DW-1:0] m_value = '0;
  logic [IW-1:0] m_last  = '0;
  int            m_ptr   = 0;

  function automatic int model_pick();
    if (rst || flush || (m_write && rob_stall)) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = model_pick();
    if (rst) begin
      m_write = 1'b0; m_idx = '0; m_value = '0; m_last = '0; m_ptr = 0;
    end else if (flush) begin
      m_write = 1'b0; m_ptr = 0;
    end else if (!(m_write && rob_stall)) begin
      if (g >= 0) begin
        m_write = 1'b1;
        m_idx   = fu[g].tag;
        m_value = fu[g].data;
        m_last  = g[IW-1:0];
        m_ptr   = (g + 1) % N;
      end else begin
        m_write = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (cmp_en) begin
      g  = model_pick();
      er = (g >= 0) ? N'(1 << g) : '0;
      check("model_ready", req_ready, er);
      check("model_write", rob_write, m_write);
      check("model_idx",   rob_idx,   m_idx);
      check("model_value", rob_value, m_value);
      check("model_last",  last_grant, m_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rob_stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < N; i++) fu[i] = '0;

    // Reset, then a single request
    tick();
    cmp_en = 1'b1;
    tick();
    @(negedge clk);
    check("rst_write", rob_write, 1'b0);
    check("rst_idx",   rob_idx,   5'd0);
    check("rst_value", rob_value, 32'd0);
    check("rst_last",  last_grant, 2'd0);
    check("rst_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b0;
    fu[0] = '{tag: 5'd7, data: 32'hDEADBEEF};
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_write", rob_write, 1'b1);
    check("t1_idx",   rob_idx,   5'd7);
    check("t1_value", rob_value, 32'hDEADBEEF);
    check("t1_last",  last_grant, 2'd0);
    tick();
    @(negedge clk);
    check("t1_idle", rob_write, 1'b0);

    // Round robin from pointer 0 with all four valid
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < N; i++) fu[i] = '{tag: TW'(i + 1), data: 32'h100 + i};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] e;
      e = N'(1 << (k % N));
      @(negedge clk);
      check("rr_ready", req_ready, e);
      if (k > 0) check("rr_idx", rob_idx, TW'(((k - 1) % N) + 1));
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    check("rr_wrap_idx",  rob_idx,    5'd1);
    check("rr_wrap_last", last_grant, 2'd0);
    tick();

    // Stall hold after a grant to FU2
    fu[2] = '{tag: 5'd9, data: 32'h0000_9999};
    req_valid = 4'b0100;
    @(negedge clk);
    check("st_ready_fu2", req_ready, 4'b0100);
    tick();
    rob_stall = 1'b1;
    fu[0] = '{tag: 5'd10, data: 32'h0000_AAAA};
    fu[1] = '{tag: 5'd11, data: 32'h0000_BBBB};
    fu[3] = '{tag: 5'd13, data: 32'h0000_DDDD};
    req_valid = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("st_ready", req_ready, 4'b0000);
      check("st_write", rob_write, 1'b1);
      check("st_idx",   rob_idx,   5'd9);
      tick();
    end
    rob_stall = 1'b0;
    @(negedge clk);
    check("st_rel_ready", req_ready, 4'b1000);
    check("st_rel_idx",   rob_idx,   5'd9);
    tick();
    req_valid = 4'b0011;
    @(negedge clk);
    check("st_fu3_idx",  rob_idx,    5'd13);
    check("st_fu3_last", last_grant, 2'd3);
    check("st_fu0_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("st_fu0_idx", rob_idx, 5'd10);
    tick();

    // Flush while a write is held under stall
    fu[0] = '{tag: 5'd12, data: 32'h0000_C0C0};
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    rob_stall = 1'b1;
    @(negedge clk);
    check("fl_held_idx", rob_idx, 5'd12);
    tick();
    flush = 1'b1;
    req_valid = 4'b0110;
    @(negedge clk);
    check("fl_ready", req_ready, 4'b0000);
    tick();
    flush = 1'b0;
    rob_stall = 1'b0;
    @(negedge clk);
    check("fl_write", rob_write, 1'b0);
    check("fl_idx_hold", rob_idx, 5'd12);
    check("fl_first_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    check("fl_fu1_idx",  rob_idx,    5'd11);
    check("fl_fu1_last", last_grant, 2'd1);
    tick();
    req_valid = '0;
    tick();

    // Reset in the middle of streaming
    req_valid = 4'b1111;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mr_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mr_write", rob_write, 1'b0);
    check("mr_last",  last_grant, 2'd0);
    check("mr_ready_fu0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("mr_fu0_idx", rob_idx, 5'd12);
    tick();

    // Sparse and late requests
    fu[3] = '{tag: 5'd20, data: 32'h0000_3333};
    req_valid = 4'b1000;
    @(negedge clk);
    check("sp_ready_fu3", req_ready, 4'b1000);
    tick();
    fu[0] = '{tag: 5'd21, data: 32'h0000_2100};
    fu[3] = '{tag: 5'd22, data: 32'h0000_2200};
    req_valid = 4'b1001;
    @(negedge clk);
    check("sp_ready_fu0", req_ready, 4'b0001);
    check("sp_idx_20",    rob_idx,   5'd20);
    tick();
    req_valid = 4'b1000;
    @(negedge clk);
    check("sp_ready_fu3b", req_ready, 4'b1000);
    check("sp_write_b",    rob_write, 1'b1);
    check("sp_idx_21",     rob_idx,   5'd21);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("sp_write_c", rob_write, 1'b1);
    check("sp_idx_22",  rob_idx,   5'd22);
    check("sp_last_3",  last_grant, 2'd3);
    tick();
    @(negedge clk);
    check("sp_idle", rob_write, 1'b0);
    tick();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
